// File: rtl/usb_buffer_pkg.sv
// Shared sizing constants for the USB data buffer and its storage array.
package usb_buffer_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int OCC_W_DEF = 7;
  localparam int PTR_W     = $clog2(DEPTH_DEF);

endpackage

// File: rtl/usb_buffer_mem.sv
// DEPTH x 8 register file: one synchronous write port, one asynchronous read port.
module usb_buffer_mem
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = PTR_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  // Contents are never initialised; the FIFO control masks stale entries.
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/usb_data_buffer.sv
// Single circular byte FIFO shared between the AHB side and the USB RX/TX sides,
// with show-ahead head output, occupancy count and overflow/underflow pulses.
module usb_data_buffer
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int OCC_W = OCC_W_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_rx_data,
  output logic [7:0]       rx_data,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_wdata;
  logic             w_empty;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_we;
  logic [7:0]       w_rdata;
  logic [7:0]       w_head;

  // Strobes carry no ready: a pop is accepted whenever the FIFO is non-empty, a
  // push whenever it is not full or a pop is accepted on the same edge. A strobe
  // that is not accepted is dropped and pulses overflow/underflow the next cycle.
  assign w_push    = store_rx_packet_data | store_tx_data;
  assign w_wdata   = store_rx_packet_data ? rx_packet_data : tx_data;
  assign w_pop     = get_rx_data | get_tx_packet_data;
  assign w_empty   = (r_occ == '0);
  assign w_full    = (r_occ == OCC_W'(DEPTH));
  assign w_pop_ok  = w_pop & ~w_empty;
  assign w_push_ok = w_push & (~w_full | w_pop_ok);
  assign w_we      = w_push_ok & ~clear & n_rst;

  usb_buffer_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_occ       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_occ <= r_occ + 1'b1;
      else if (w_pop_ok && !w_push_ok) r_occ <= r_occ - 1'b1;
      r_overflow  <= w_push & ~w_push_ok;
      r_underflow <= w_pop & ~w_pop_ok;
    end
  end

  // Empty FIFO presents zero rather than whatever stale byte sits at rptr.
  assign w_head           = w_empty ? 8'h00 : w_rdata;
  assign rx_data          = w_head;
  assign tx_packet_data   = w_head;
  assign buffer_occupancy = r_occ;
  assign overflow         = r_overflow;
  assign underflow        = r_underflow;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: directed scenarios plus randomized
// traffic compared each cycle against a queue-based reference model.
module tb_usb_data_buffer;

  localparam int DEPTH = 64;
  localparam int OCC_W = 7;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             clear;
  logic             store_tx_data;
  logic [7:0]       tx_data;
  logic             get_rx_data;
  logic [7:0]       rx_data;
  logic             store_rx_packet_data;
  logic [7:0]       rx_packet_data;
  logic             get_tx_packet_data;
  logic [7:0]       tx_packet_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic             overflow;
  logic             underflow;

  always #5 clk = ~clk;

  usb_data_buffer #(.DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .overflow             (overflow),
    .underflow            (underflow)
  );

  // Reference model state
  logic [7:0] exp_q[$];
  logic       exp_ovf;
  logic       exp_udf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic set_in(input logic rst_n, input logic clr,
                        input logic stx, input logic [7:0] txd,
                        input logic srx, input logic [7:0] rxd,
                        input logic grx, input logic gtx);
    n_rst                = rst_n;
    clear                = clr;
    store_tx_data        = stx;
    tx_data              = txd;
    store_rx_packet_data = srx;
    rx_packet_data       = rxd;
    get_rx_data          = grx;
    get_tx_packet_data   = gtx;
  endtask

  task automatic idle_in();
    set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] exp_head();
    return (exp_q.size() == 0) ? 8'h00 : exp_q[0];
  endfunction

  task automatic compare_all();
    chk("occupancy", buffer_occupancy, exp_q.size());
    chk("rx_data", rx_data, exp_head());
    chk("tx_packet_data", tx_packet_data, exp_head());
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_udf);
  endtask

  // Behaviour of one clock edge given the inputs currently applied.
  task automatic model_edge();
    logic       push, pop, pop_ok, push_ok;
    logic [7:0] d;
    if (!n_rst || clear) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      push    = store_tx_data | store_rx_packet_data;
      d       = store_rx_packet_data ? rx_packet_data : tx_data;
      pop     = get_rx_data | get_tx_packet_data;
      pop_ok  = pop && (exp_q.size() > 0);
      push_ok = push && ((exp_q.size() < DEPTH) || pop_ok);
      if (pop_ok)  void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(d);
      exp_ovf = push && !push_ok;
      exp_udf = pop && !pop_ok;
    end
  endtask

  // Inputs are already applied: check current outputs mid-cycle, take the edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    set_in(1'b1, 1'b0, 1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
  endtask

  task automatic pop_one();
    set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle();
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_in();
    cycle();
    chk("reset_occ", buffer_occupancy, 0);
    chk("reset_head", rx_data, 8'h00);

    // Single push of A5 shows at the head one cycle later
    push_tx(8'hA5);
    chk("a5_occ", buffer_occupancy, 1);
    chk("a5_rx", rx_data, 8'hA5);
    chk("a5_tx", tx_packet_data, 8'hA5);
    pop_one();

    // Fill to full, then one more push is dropped
    for (int i = 0; i < DEPTH; i++) push_tx(8'(i));
    push_tx(8'hFF);
    chk("full_occ", buffer_occupancy, 64);
    chk("full_ovf", overflow, 1'b1);
    idle_in();
    cycle();
    chk("ovf_one_cycle", overflow, 1'b0);

    // Push with pop at full is accepted
    chk("head_0", rx_data, 8'h00);
    set_in(1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle();
    chk("pp_occ", buffer_occupancy, 64);
    chk("pp_ovf", overflow, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain_order", tx_packet_data, 8'(i));
      pop_one();
    end
    chk("emerge_11", rx_data, 8'h11);
    pop_one();

    // Pop when empty
    pop_one();
    chk("udf_pulse", underflow, 1'b1);
    chk("udf_occ", buffer_occupancy, 0);
    chk("udf_head", rx_data, 8'h00);
    idle_in();
    cycle();
    chk("udf_one_cycle", underflow, 1'b0);

    // Both push strobes: USB-RX byte wins
    set_in(1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 8'h22, 1'b0, 1'b0);
    cycle();
    chk("both_head", rx_data, 8'h22);
    chk("both_occ", buffer_occupancy, 1);

    // Clear with a push at occupancy 10
    for (int i = 0; i < 9; i++) push_tx(8'($urandom_range(0, 255)));
    chk("ten_occ", buffer_occupancy, 10);
    set_in(1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle();
    chk("clr_occ", buffer_occupancy, 0);
    chk("clr_head", tx_packet_data, 8'h00);
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_udf", underflow, 1'b0);

    // Reset mid-stream with strobes active
    for (int i = 0; i < 5; i++) push_tx(8'(i + 8'h50));
    set_in(1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 8'h77, 1'b1, 1'b1);
    cycle();
    chk("rst_occ", buffer_occupancy, 0);
    chk("rst_head", rx_data, 8'h00);
    chk("rst_ovf", overflow, 1'b0);

    // Randomized traffic with phases that drive the FIFO to full and to empty
    for (int i = 0; i < 2000; i++) begin
      int push_pct;
      int phase;
      phase = (i / 250) % 4;
      case (phase)
        0:       push_pct = 90;
        1:       push_pct = 15;
        2:       push_pct = 55;
        default: push_pct = 70;
      endcase
      set_in(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 99) == 0),
             ($urandom_range(0, 99) < push_pct),
             8'($urandom_range(0, 255)),
             ($urandom_range(0, 99) < push_pct / 2),
             8'($urandom_range(0, 255)),
             ($urandom_range(0, 99) < 100 - push_pct),
             ($urandom_range(0, 99) < (100 - push_pct) / 2));
      cycle();
    end

    idle_in();
    cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_data_buffer.md
USB_DATA_BUFFER -- requirements
Module: usb_data_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of byte entries (power of two).
REQ-002 SHALL have parameter OCC_W, default 7, meaning occupancy width, equal to log2(DEPTH)+1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port n_rst, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port clear, input, 1 bit: flush request from the AHB-side register file.
REQ-006 SHALL have port store_tx_data, input, 1 bit: AHB-side push strobe.
REQ-007 SHALL have port tx_data, input, 8 bits: AHB-side push byte.
REQ-008 SHALL have port get_rx_data, input, 1 bit: AHB-side pop strobe.
REQ-009 SHALL have port rx_data, output, 8 bits: head byte presented to the AHB side.
REQ-010 SHALL have port store_rx_packet_data, input, 1 bit: USB-RX-side push strobe.
REQ-011 SHALL have port rx_packet_data, input, 8 bits: USB-RX-side push byte.
REQ-012 SHALL have port get_tx_packet_data, input, 1 bit: USB-TX-side pop strobe.
REQ-013 SHALL have port tx_packet_data, output, 8 bits: head byte presented to the USB-TX side.
REQ-014 SHALL have port buffer_occupancy, output, OCC_W bits: number of valid bytes, range 0..DEPTH.
REQ-015 SHALL have port overflow, output, 1 bit: one-cycle pulse when a push is dropped.
REQ-016 SHALL have port underflow, output, 1 bit: one-cycle pulse when a pop is dropped.

Function
REQ-017 SHALL be a single circular FIFO with a write pointer, a read pointer and an occupancy counter.
REQ-018 SHALL compute effective push = store_rx_packet_data OR store_tx_data.
REQ-019 SHALL take push data from rx_packet_data when both push strobes are high; the AHB byte is dropped silently.
REQ-020 SHALL compute effective pop = get_rx_data OR get_tx_packet_data; simultaneous pops count as one pop.
REQ-021 SHALL be show-ahead: rx_data and tx_data_packet both equal mem[rptr] combinationally.
REQ-022 SHALL hold rx_data and tx_packet_data at 8'h00 while occupancy is 0.
REQ-023 SHALL write the byte and advance wptr on the clock edge of an accepted push; byte visible at head next cycle if the FIFO was empty.
REQ-024 SHALL advance rptr on the clock edge of an accepted pop.
REQ-025 SHALL wrap pointers modulo DEPTH (63 -> 0 at default).
REQ-026 SHALL increment occupancy on push-only, decrement on pop-only, and hold it on push+pop.
REQ-027 SHALL reject a push when full (occupancy == DEPTH) unless a pop is accepted in the same cycle, and SHALL assert overflow for one cycle on rejection.
REQ-028 SHALL reject a pop when empty, assert underflow for one cycle, and ignore any same-cycle push-as-bypass (push is still accepted normally).
REQ-029 SHALL, on clear, zero wptr, rptr and occupancy on the next edge, overriding any same-cycle push or pop, with no overflow/underflow pulse.
REQ-030 SHALL not require memory contents to be cleared by clear or reset.

Reset
REQ-031 SHALL, when n_rst is low at a posedge, set wptr=0, rptr=0, buffer_occupancy=0, overflow=0, underflow=0; rx_data and tx_packet_data then read 8'h00.
REQ-032 SHALL abandon any in-progress push/pop on reset mid-operation; no strobe during the reset edge takes effect.

Structure
REQ-033 SHALL place DEPTH, OCC_W defaults and pointer width constant in shared package usb_buffer_pkg.
REQ-034 SHALL instantiate one sub-module usb_buffer_mem (DEPTH x 8 register file, 1 synchronous write port, 1 asynchronous read port).

Verification
REQ-035 SHALL cover: reset, push 8'hA5 via store_tx_data -> next cycle occupancy=1, rx_data=tx_packet_data=8'hA5.
REQ-036 SHALL cover: 64 pushes of 0..63 then push 8'hFF -> occupancy=64, overflow pulses once, 64 pops return 0..63 in order.
REQ-037 SHALL cover: pop when empty -> underflow pulses one cycle, occupancy stays 0, outputs 8'h00.
REQ-038 SHALL cover: at occupancy 64, push 8'h11 with pop -> accepted, occupancy stays 64, no overflow, 8'h11 emerges after 63 more pops.
REQ-039 SHALL cover: both push strobes with rx_packet_data=8'h22, tx_data=8'h33 -> only 8'h22 stored, occupancy +1.
REQ-040 SHALL cover: occupancy 10, clear asserted with push -> next cycle occupancy=0, outputs 8'h00, no pulses; then n_rst low mid-stream -> same zeroed state.
